// File: rtl/ncl_dr_source_pkg.sv
// Shared NCL definitions: rail encodings, source FSM states and the
// single-rail to dual-rail encoder.
package ncl_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_T    = 2'b10;
  localparam logic [1:0] DR_F    = 2'b01;

  typedef enum logic [2:0] {WAIT_N, IDLE, DATA, NULLW, ERR} state_e;

  function automatic logic [1:0] to_dual_rail(input logic b);
    return b ? DR_T : DR_F;
  endfunction

endpackage

// File: rtl/ncl_dr_source_if.sv
// Operand handshake, dual-rail wavefront bus and status of the NCL source.
interface ncl_dr_source_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [2*N-1:0]   dr_out;
  logic             comp_in;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] wave_count;

  modport master (
    output in_valid, in_data, comp_in,
    input  in_ready, dr_out, busy, timeout_err, wave_count
  );

  modport slave (
    input  in_valid, in_data, comp_in,
    output in_ready, dr_out, busy, timeout_err, wave_count
  );
endinterface

// File: rtl/ncl_dr_source_sync2.sv
// Two-flop synchronizer for the asynchronous completion input.
module ncl_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];
endmodule

// File: rtl/ncl_dr_source.sv
// Clocked front end of the NCL multiplier array: issues DATA/NULL dual-rail
// wavefronts paced by downstream completion, with a stall timeout.
module ncl_dr_source
  import ncl_pkg::*;
#(
  parameter int N       = 8,
  parameter int TMO_CYC = 1024,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            init,
  ncl_dr_source_if.slave  bus
);
  localparam int TW = (TMO_CYC > 4) ? $clog2(TMO_CYC) : 2;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [N-1:0][1:0]   dr_q, dr_d, dr_enc;
  logic [CNT_W-1:0]    wave_q;
  logic                comp_s, accept, tmr_exp, wave_inc, tmr_run;

  ncl_sync2 u_sync (.clk(clk), .rst(init), .d(bus.comp_in), .q(comp_s));

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign dr_enc[i] = to_dual_rail(bus.in_data[i]);
  end

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign tmr_exp = (tmr_q == TMO_LAST);
  assign tmr_run = (state_q == WAIT_N) || (state_q == DATA) || (state_q == NULLW);

  always_comb begin
    state_d  = state_q;
    wave_inc = 1'b0;
    case (state_q)
      // sync flops restart at 0, so wait until they hold two real samples
      WAIT_N: if (!comp_s && (tmr_q >= TW'(2))) state_d = IDLE;
              else if (tmr_exp)                 state_d = ERR;
      IDLE:   if (accept)                       state_d = DATA;
      DATA:   if (comp_s)                       state_d = NULLW;
              else if (tmr_exp)                 state_d = ERR;
      NULLW:  if (!comp_s) begin
                state_d  = IDLE;
                wave_inc = 1'b1;
              end else if (tmr_exp)             state_d = ERR;
      ERR:                                      state_d = ERR;
      default:                                  state_d = WAIT_N;
    endcase

    // DATA is loaded only from IDLE (all NULL) and held until the state leaves
    dr_d = '0;
    if (state_d == DATA) dr_d = (state_q == IDLE) ? dr_enc : dr_q;

    tmr_d = '0;
    if (tmr_run && (state_d == state_q)) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= WAIT_N;
      tmr_q   <= '0;
      dr_q    <= '0;
      wave_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dr_q    <= dr_d;
      if (wave_inc) wave_q <= wave_q + 1'b1;
    end
  end

  assign bus.dr_out      = dr_q;
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.busy        = (state_q == DATA) || (state_q == NULLW);
  assign bus.timeout_err = (state_q == ERR);
  assign bus.wave_count  = wave_q;
endmodule
